// File: rtl/mc_seq.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP control with PC, EPC and retire count.
// Latency: 3 cycles for ALU ops (plus fetch wait), 4 with writeback, MEM adds at least 1 cycle.
// Backpressure: fetch stalls indefinitely on imem_ready; MEM stalls on dmem_ready up to TIMEOUT cycles, then traps.
//
// Ports:
//   clk, rest                  clock and asynchronous active-high reset
//   imem_req/addr/ready/rdata  instruction fetch handshake; ir holds the latched instruction
//   dec_*, branch_taken,target decoder class flags and branch/jump resolution for ir
//   dmem_req/we/ready          data access handshake
//   reg_wr_en                  register file write strobe
//   irq, ie                    level interrupt request and interrupt enable
//   pc, epc, exc_cause         architectural PC, exception return address and trap cause
//   state, instret             current sequencer state and retired instruction count
module mc_seq #(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rest,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   ir,
  input  logic              dec_mem_rd,
  input  logic              dec_mem_wr,
  input  logic              dec_reg_wr,
  input  logic              dec_branch,
  input  logic              dec_jump,
  input  logic              dec_eret,
  input  logic              dec_illegal,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] target,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  output logic              reg_wr_en,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        exc_cause,
  output logic              ie,
  output logic [2:0]        state,
  output logic [31:0]       instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] CAUSE_IRQ     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  state_t           st;
  logic             fetch_wait;  // set once FETCH has spent a cycle waiting on imem_ready
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_q;     // cause captured on TRAP entry, published on TRAP exit

  logic              irq_take;
  logic              timeout_hit;
  logic [ADDR_W-1:0] next_pc;

  // Interrupts are only taken before a fetch is issued; once imem_req is up
  // it must stay up until accepted.
  assign irq_take    = (st == S_FETCH) && !fetch_wait && irq && ie;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign next_pc     = (dec_jump || (dec_branch && branch_taken)) ? target : pc + ADDR_W'(4);

  // Strobes decode from state but are gated by reset so an access in flight
  // is dropped the moment reset asserts.
  assign imem_req  = !rest && (st == S_FETCH) && !irq_take;
  assign imem_addr = pc;
  assign dmem_req  = !rest && (st == S_MEM);
  assign dmem_we   = dmem_req && dec_mem_wr;
  assign reg_wr_en = !rest && (st == S_WB);
  assign state     = st;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      st         <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      epc        <= '0;
      exc_cause  <= CAUSE_IRQ;
      ie         <= 1'b1;
      instret    <= '0;
      wait_cnt   <= '0;
      fetch_wait <= 1'b0;
      cause_q    <= CAUSE_IRQ;
    end else begin
      fetch_wait <= 1'b0;
      case (st)
        S_FETCH: begin
          if (irq_take) begin
            cause_q <= CAUSE_IRQ;
            st      <= S_TRAP;
          end else if (imem_ready) begin
            ir <= imem_rdata;
            st <= S_DECODE;
          end else begin
            fetch_wait <= 1'b1;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            cause_q <= CAUSE_ILLEGAL;
            st      <= S_TRAP;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_eret) begin
            pc      <= epc;
            ie      <= 1'b1;
            instret <= instret + 32'd1;
            st      <= S_FETCH;
          end else if (dec_mem_rd || dec_mem_wr) begin
            wait_cnt <= '0;
            st       <= S_MEM;
          end else if (dec_reg_wr) begin
            st <= S_WB;
          end else begin
            pc      <= next_pc;
            instret <= instret + 32'd1;
            st      <= S_FETCH;
          end
        end
        S_MEM: begin
          // A completion arriving on the timeout cycle still retires normally.
          if (dmem_ready) begin
            if (dec_mem_wr) begin
              pc      <= next_pc;
              instret <= instret + 32'd1;
              st      <= S_FETCH;
            end else begin
              st <= S_WB;
            end
          end else if (timeout_hit) begin
            cause_q <= CAUSE_TIMEOUT;
            st      <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          pc      <= next_pc;
          instret <= instret + 32'd1;
          st      <= S_FETCH;
        end
        S_TRAP: begin
          epc       <= pc;
          pc        <= EXC_VEC;
          ie        <= 1'b0;
          exc_cause <= cause_q;
          st        <= S_FETCH;
        end
        default: st <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_seq.sv
module tb_mc_seq;

  logic        clk = 1'b0;
  logic        rest;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_branch, dec_jump, dec_eret, dec_illegal;
  logic        branch_taken;
  logic [31:0] target;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        reg_wr_en;
  logic        irq;
  logic [31:0] pc, epc;
  logic [1:0]  exc_cause;
  logic        ie;
  logic [2:0]  state;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;

  mc_seq dut (
    .clk(clk), .rest(rest),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_wr(dec_reg_wr),
    .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_eret(dec_eret), .dec_illegal(dec_illegal),
    .branch_taken(branch_taken), .target(target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .reg_wr_en(reg_wr_en), .irq(irq),
    .pc(pc), .epc(epc), .exc_cause(exc_cause), .ie(ie), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic rd, input logic wr, input logic rw, input logic br,
                           input logic jp, input logic er, input logic il);
    dec_mem_rd = rd; dec_mem_wr = wr; dec_reg_wr = rw; dec_branch = br;
    dec_jump = jp; dec_eret = er; dec_illegal = il;
  endtask

  // Present one instruction in FETCH with imem_ready high; returns in DECODE.
  task automatic issue(input logic [31:0] instr);
    imem_rdata = instr;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rest = 1'b1;
    #2;
    checks++; if (state !== ST_FETCH) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_FETCH); end
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    checks++; if (ir !== 32'h0 || epc !== 32'h0 || exc_cause !== 2'd0) begin errors++; $display("FAIL reset_regs ir=%h epc=%h cause=%0d exp all zero", ir, epc, exc_cause); end
    checks++; if (ie !== 1'b1 || instret !== 32'd0) begin errors++; $display("FAIL reset_ie_instret ie=%b instret=%0d exp ie=1 instret=0", ie, instret); end
    checks++; if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_strobes imem=%b dmem=%b we=%b rw=%b exp 0000", imem_req, dmem_req, dmem_we, reg_wr_en); end
    tick(); tick();
    rest = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL first_fetch req=%b addr=%h exp req=1 addr=3000", imem_req, imem_addr); end
  endtask

  task automatic test_add();
    set_flags(0, 0, 1, 0, 0, 0, 0);
    issue(32'h00B5_0533);
    checks++; if (state !== ST_DECODE || ir !== 32'h00B5_0533) begin errors++; $display("FAIL add_decode state=%0d ir=%h exp 1 / 00b50533", state, ir); end
    tick();
    checks++; if (state !== ST_EXEC || reg_wr_en !== 1'b0) begin errors++; $display("FAIL add_exec state=%0d rw=%b exp 2 / 0", state, reg_wr_en); end
    tick();
    checks++; if (state !== ST_WB || reg_wr_en !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL add_wb state=%0d rw=%b imem=%b dmem=%b exp 4/1/0/0", state, reg_wr_en, imem_req, dmem_req); end
    tick();
    checks++; if (state !== ST_FETCH || reg_wr_en !== 1'b0) begin errors++; $display("FAIL add_wb_once state=%0d rw=%b exp 0 / 0", state, reg_wr_en); end
    checks++; if (pc !== 32'h3004 || instret !== 32'd1) begin errors++; $display("FAIL add_retire pc=%h instret=%0d exp 3004 / 1", pc, instret); end
  endtask

  task automatic test_load();
    set_flags(1, 0, 1, 0, 0, 0, 0);
    issue(32'h0005_2503);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== ST_MEM || dmem_req !== 1'b1 || dmem_we !== 1'b0) begin errors++; $display("FAIL load_mem_%0d state=%0d req=%b we=%b exp 3/1/0", i, state, dmem_req, dmem_we); end
      if (i == 3) dmem_ready = 1'b1;
      tick();
    end
    dmem_ready = 1'b0;
    checks++; if (state !== ST_WB || reg_wr_en !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL load_wb state=%0d rw=%b dmem=%b exp 4/1/0", state, reg_wr_en, dmem_req); end
    tick();
    checks++; if (pc !== 32'h3008 || instret !== 32'd2) begin errors++; $display("FAIL load_retire pc=%h instret=%0d exp 3008 / 2", pc, instret); end
  endtask

  task automatic test_branch();
    set_flags(0, 0, 0, 1, 0, 0, 0);
    target = 32'h3100;
    branch_taken = 1'b1;
    issue(32'h0000_0863);
    tick();
    tick();
    checks++; if (state !== ST_FETCH || pc !== 32'h3100 || instret !== 32'd3) begin errors++; $display("FAIL branch_taken state=%0d pc=%h instret=%0d exp 0/3100/3", state, pc, instret); end
    // Taken level during DECODE only; it must be ignored at the EXEC exit.
    branch_taken = 1'b1;
    issue(32'h0000_0863);
    tick();
    branch_taken = 1'b0;
    tick();
    checks++; if (pc !== 32'h3104 || instret !== 32'd4) begin errors++; $display("FAIL branch_not_taken pc=%h instret=%0d exp 3104 / 4", pc, instret); end
  endtask

  task automatic test_irq_eret();
    set_flags(0, 0, 0, 0, 0, 0, 0);
    irq = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL irq_no_fetch imem_req=%b exp 0", imem_req); end
    tick();
    irq = 1'b0;
    checks++; if (state !== ST_TRAP) begin errors++; $display("FAIL irq_trap state=%0d exp 5", state); end
    tick();
    checks++; if (pc !== 32'h4180 || epc !== 32'h3104 || exc_cause !== 2'd0 || ie !== 1'b0 || instret !== 32'd4) begin errors++; $display("FAIL irq_regs pc=%h epc=%h cause=%0d ie=%b instret=%0d exp 4180/3104/0/0/4", pc, epc, exc_cause, ie, instret); end
    set_flags(0, 0, 0, 0, 0, 1, 0);
    issue(32'h3020_0073);
    tick();
    tick();
    checks++; if (state !== ST_FETCH || pc !== 32'h3104 || ie !== 1'b1 || instret !== 32'd5) begin errors++; $display("FAIL eret state=%0d pc=%h ie=%b instret=%0d exp 0/3104/1/5", state, pc, ie, instret); end
  endtask

  task automatic test_store_timeout();
    set_flags(0, 1, 0, 0, 0, 0, 0);
    issue(32'h00A5_2023);
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++; if (state !== ST_MEM || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL store_mem_%0d state=%0d req=%b we=%b exp 3/1/1", i, state, dmem_req, dmem_we); end
      tick();
    end
    checks++; if (state !== ST_TRAP || dmem_req !== 1'b0) begin errors++; $display("FAIL store_trap state=%0d dmem=%b exp 5 / 0", state, dmem_req); end
    tick();
    checks++; if (exc_cause !== 2'd2 || epc !== 32'h3104 || pc !== 32'h4180 || ie !== 1'b0 || instret !== 32'd5) begin errors++; $display("FAIL store_timeout cause=%0d epc=%h pc=%h ie=%b instret=%0d exp 2/3104/4180/0/5", exc_cause, epc, pc, ie, instret); end
  endtask

  task automatic test_illegal();
    set_flags(0, 0, 1, 0, 0, 0, 1);
    issue(32'hFFFF_FFFF);
    checks++; if (state !== ST_DECODE) begin errors++; $display("FAIL illegal_decode state=%0d exp 1", state); end
    tick();
    checks++; if (state !== ST_TRAP || reg_wr_en !== 1'b0) begin errors++; $display("FAIL illegal_trap state=%0d rw=%b exp 5 / 0", state, reg_wr_en); end
    tick();
    checks++; if (state !== ST_FETCH || reg_wr_en !== 1'b0 || exc_cause !== 2'd1 || epc !== 32'h4180 || pc !== 32'h4180 || instret !== 32'd5) begin errors++; $display("FAIL illegal_regs state=%0d rw=%b cause=%0d epc=%h pc=%h instret=%0d exp 0/0/1/4180/4180/5", state, reg_wr_en, exc_cause, epc, pc, instret); end
  endtask

  task automatic test_reset_mid_mem();
    set_flags(1, 0, 1, 0, 0, 0, 0);
    issue(32'h0005_2503);
    tick();
    tick();
    tick();
    checks++; if (state !== ST_MEM || dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mem_pre state=%0d dmem=%b exp 3 / 1", state, dmem_req); end
    #2;
    rest = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || state !== ST_FETCH || imem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_drop dmem=%b state=%0d imem=%b exp 0/0/0", dmem_req, state, imem_req); end
    tick();
    set_flags(0, 0, 0, 0, 0, 0, 0);
    rest = 1'b0;
    #1;
    checks++; if (pc !== 32'h3000 || instret !== 32'd0 || ie !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL rst_mem_post pc=%h instret=%0d ie=%b imem=%b addr=%h exp 3000/0/1/1/3000", pc, instret, ie, imem_req, imem_addr); end
  endtask

  initial begin
    rest = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    target = '0;
    irq = 1'b0;
    set_flags(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_irq_eret();
    test_store_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_seq.md
MC_SEQ -- requirements
Module: mc_seq

Interface
REQ-001 The block SHALL have these parameters: XLEN, default 32, datapath/instruction width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_3000, PC value after reset.
REQ-004 The block SHALL have parameter EXC_VEC, default 32'h0000_4180, trap entry address.
REQ-005 The block SHALL have parameter TIMEOUT, default 16, max MEM wait cycles; 0 disables timeout.
REQ-006 The block SHALL have these ports (name direction width meaning):
  clk  in  1  single clock, rising edge
  rest  in  1  asynchronous, active-high reset
  imem_req  out  1  fetch request
  imem_addr  out  ADDR_W  fetch address (= pc)
  imem_ready  in  1  fetch accepted, imem_rdata valid
  imem_rdata  in  XLEN  fetched instruction
  ir  out  XLEN  latched instruction for decoder
  dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_branch, dec_jump, dec_eret, dec_illegal  in  1 each  decoder class flags for ir
  branch_taken  in  1  ALU branch condition
  target  in  ADDR_W  branch/jump target
  dmem_req  out  1  data access request
  dmem_we  out  1  data write (valid with dmem_req)
  dmem_ready  in  1  data access complete
  reg_wr_en  out  1  register file write strobe
  irq  in  1  level interrupt request
  pc  out  ADDR_W  current instruction address
  epc  out  ADDR_W  exception return address
  exc_cause  out  2  0 irq, 1 illegal, 2 bus timeout
  ie  out  1  interrupt enable
  state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
  instret  out  32  retired instruction count

Function
REQ-007 FETCH: imem_req=1 every cycle; if irq&ie on the first FETCH cycle, go TRAP (cause 0) without request; on imem_req&imem_ready, ir<=imem_rdata, go DECODE.
REQ-008 imem_req SHALL stay high until imem_ready; fetch wait is unbounded.
REQ-009 DECODE: one cycle; dec_illegal -> TRAP (cause 1), else EXEC.
REQ-010 EXEC: one cycle; dec_eret -> pc<=epc, ie<=1, FETCH; dec_mem_rd|dec_mem_wr -> MEM; else dec_reg_wr -> WB; else FETCH.
REQ-011 MEM: dmem_req=1, dmem_we=dec_mem_wr; on dmem_ready, load -> WB, store -> FETCH.
REQ-012 MEM wait counter SHALL clear on MEM entry; when TIMEOUT!=0 and TIMEOUT cycles elapse without dmem_ready, go TRAP (cause 2); dmem_ready on the timeout cycle wins.
REQ-013 WB: reg_wr_en=1 for exactly one cycle, then FETCH.
REQ-014 On normal return to FETCH (not eret, not TRAP): pc<=target if dec_jump or (dec_branch&branch_taken), else pc<=pc+4 modulo 2^ADDR_W.
REQ-015 instret SHALL increment by 1 (wrapping) on each normal return to FETCH and on eret; never on TRAP.
REQ-016 TRAP: one cycle; epc<=pc, pc<=EXC_VEC, ie<=0, exc_cause<=cause; then FETCH.
REQ-017 reg_wr_en, dmem_req, imem_req SHALL never be high in the same cycle; no register write on trapped instructions.
REQ-018 Decoder flags and branch_taken SHALL be sampled only in EXEC/MEM/WB exit cycles; changes elsewhere ignored.

Reset
REQ-019 rest high SHALL immediately force state=FETCH, pc=RESET_PC, ir=0, epc=0, exc_cause=0, ie=1, instret=0, wait counter=0.
REQ-020 While rest high, imem_req, dmem_req, dmem_we, reg_wr_en SHALL be 0; reset mid-access abandons the access.
REQ-021 First imem_req SHALL assert in the first cycle after rest deasserts, with imem_addr=RESET_PC.

Verification
REQ-022 Reset, imem_ready=1, ir=ADD (dec_reg_wr): FETCH,DECODE,EXEC,WB; reg_wr_en one cycle; pc=0x3004, instret=1.
REQ-023 Load with dmem_ready after 3 cycles: MEM held 4 cycles, dmem_we=0, then WB; pc=+4.
REQ-024 Store, dmem_ready never, TIMEOUT=16: TRAP after 16 MEM cycles; exc_cause=2, epc=faulting pc, pc=0x4180, ie=0, instret unchanged.
REQ-025 irq=1, ie=1 at FETCH: no imem_req, TRAP cause 0, epc=pc; then eret instruction: pc=epc, ie=1, instret+1.
REQ-026 Branch taken, target=0x3100: pc=0x3100; not taken: pc+4; dec_illegal: TRAP cause 1, no reg_wr_en.
REQ-027 Assert rest during MEM wait: dmem_req drops same cycle; post-reset pc=0x3000, instret=0.
